// File: rtl/register_file_bank_scheduler_pkg.sv
// Shared compute-unit definitions for the register file bank scheduler.
// Typedefs describe the default configuration (4 readers, 32 x 32-bit
// registers, 4-bit tags); the scheduler itself is parameterized and sizes
// its ports from its own parameters.
package register_file_bank_scheduler_pkg;

  localparam int NumReadersDef   = 4;
  localparam int NumRegistersDef = 32;
  localparam int DataWidthDef    = 32;
  localparam int TagWidthDef     = 4;
  localparam int MaxWrStreakDef  = 3;

  // Bank read data arrives exactly this many cycles after a read accept.
  localparam int RfReadLatency   = 1;

  // Width of an index over n items; never zero so n=1 still gets a wire.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(NumRegistersDef)-1:0] rf_addr_t;
  typedef logic [DataWidthDef-1:0]            rf_data_t;
  typedef logic [TagWidthDef-1:0]             rf_tag_t;
  typedef logic [idx_width(NumReadersDef)-1:0] reader_idx_t;

endpackage

// File: rtl/register_file_bank_scheduler_rr_picker.sv
// rf_rr_picker: combinational round-robin priority pick.
// Ports:
//   valid_i     N   request vector
//   ptr_i       IW  highest-priority index this cycle (< N)
//   grant_o     IW  first valid index at or after ptr_i, wrapping (0 if none)
//   any_valid_o 1   some request is valid
module rf_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_valid_o
);

  assign any_valid_o = |valid_i;

  // Walk offsets from farthest to nearest so the nearest valid index to
  // ptr_i is the last (winning) assignment.
  always_comb begin
    int k;
    logic [IW-1:0] idx;
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      idx = IW'(k);
      if (valid_i[idx]) grant_o = idx;
    end
  end

endmodule

// File: rtl/register_file_bank_scheduler.sv
// register_file_bank_scheduler: shares one single-port register file bank
// between NumReaders read requesters and one writeback port.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   rd_valid_i/ready_o/addr_i/tag_i  per-requester read handshake
//   wr_valid_i/ready_o/addr_i/data_i writeback handshake
//   bank_wr_*                   write port toward the bank (writes win there)
//   bank_rd_*                   read request toward the bank
//   bank_rsp_valid_i/data_i     bank read data, one cycle after accept
//   rsp_valid_o/tag_o/data_o    one-hot response to the requester, no backpressure
// Readers are picked round-robin; a streak guard forces one write-free slot
// after MaxWrStreak consecutive write-blocked read cycles.
module register_file_bank_scheduler
  import register_file_bank_scheduler_pkg::*;
#(
  parameter int NumReaders   = NumReadersDef,
  parameter int NumRegisters = NumRegistersDef,
  parameter int DataWidth    = DataWidthDef,
  parameter int TagWidth     = TagWidthDef,
  parameter int MaxWrStreak  = MaxWrStreakDef,
  localparam int AW = $clog2(NumRegisters),
  localparam int TW = TagWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReaders-1:0]          rd_valid_i,
  output logic [NumReaders-1:0]          rd_ready_o,
  input  logic [NumReaders-1:0][AW-1:0]  rd_addr_i,
  input  logic [NumReaders-1:0][TW-1:0]  rd_tag_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [AW-1:0]                  wr_addr_i,
  input  logic [DataWidth-1:0]           wr_data_i,
  output logic                           bank_wr_valid_o,
  output logic [AW-1:0]                  bank_wr_addr_o,
  output logic [DataWidth-1:0]           bank_wr_data_o,
  input  logic                           bank_wr_ready_i,
  output logic                           bank_rd_valid_o,
  output logic [AW-1:0]                  bank_rd_addr_o,
  input  logic                           bank_rd_ready_i,
  input  logic                           bank_rsp_valid_i,
  input  logic [DataWidth-1:0]           bank_rsp_data_i,
  output logic [NumReaders-1:0]          rsp_valid_o,
  output logic [TW-1:0]                  rsp_tag_o,
  output logic [DataWidth-1:0]           rsp_data_o
);

  localparam int IW = idx_width(NumReaders);
  localparam int SW = (MaxWrStreak > 0) ? $clog2(MaxWrStreak + 1) : 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic          any_valid;
  logic          rd_accept;
  logic          force_rd;
  logic [SW-1:0] streak;
  logic          inflight_valid;
  logic [IW-1:0] inflight_idx;
  logic [TW-1:0] inflight_tag;

  rf_rr_picker #(.N(NumReaders), .IW(IW)) u_picker (
    .valid_i     (rd_valid_i),
    .ptr_i       (rr_ptr),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  // ---------------- write path / starvation guard ----------------
  assign force_rd = (MaxWrStreak != 0) && (streak == SW'(MaxWrStreak)) && any_valid;

  assign bank_wr_valid_o = wr_valid_i & ~force_rd;
  assign wr_ready_o      = bank_wr_ready_i & ~force_rd;
  assign bank_wr_addr_o  = wr_addr_i;
  assign bank_wr_data_o  = wr_data_i;

  // ---------------- read path ----------------
  assign bank_rd_valid_o = any_valid;
  assign bank_rd_addr_o  = rd_addr_i[grant];
  assign rd_accept       = any_valid & bank_rd_ready_i;

  always_comb begin
    rd_ready_o        = '0;
    rd_ready_o[grant] = rd_accept;
  end

  generate
    if (NumReaders == 1) begin : g_single
      assign rr_ptr = '0;
    end else begin : g_rr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        rr_ptr <= '0;
        else if (rd_accept) rr_ptr <= (grant == IW'(NumReaders - 1)) ? '0 : grant + IW'(1);
      end
    end
  endgenerate

  // Counts consecutive cycles where a read waits behind a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         streak <= '0;
    else if (rd_accept || !any_valid)    streak <= '0;
    else if (streak != SW'(MaxWrStreak)) streak <= streak + SW'(1);
  end

  // ---------------- in-flight tracking ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_valid <= 1'b0;
      inflight_idx   <= '0;
      inflight_tag   <= '0;
    end else begin
      inflight_valid <= rd_accept;
      if (rd_accept) begin
        inflight_idx <= grant;
        inflight_tag <= rd_tag_i[grant];
      end
    end
  end

  // Gating with inflight_valid keeps a stale bank response (e.g. across a
  // reset) from reaching a requester.
  always_comb begin
    rsp_valid_o               = '0;
    rsp_valid_o[inflight_idx] = inflight_valid & bank_rsp_valid_i;
  end
  assign rsp_tag_o  = inflight_tag;
  assign rsp_data_o = bank_rsp_data_i;

  // ---------------- protocol checks ----------------
  a_rsp_matches_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bank_rsp_valid_i == inflight_valid);
  a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o));
  a_wr_not_forced: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_ready_o |-> !force_rd);

endmodule

// File: tb/tb_register_file_bank_scheduler.sv
module tb_register_file_bank_scheduler;
  import register_file_bank_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int MS = 3;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 readers, guard = 3) ----------------
  logic [N-1:0]          rd_valid_i, rd_ready_o, rsp_valid_o;
  logic [N-1:0][AW-1:0]  rd_addr_i;
  logic [N-1:0][TW-1:0]  rd_tag_i;
  logic                  wr_valid_i, wr_ready_o;
  logic [AW-1:0]         wr_addr_i, bank_wr_addr_o, bank_rd_addr_o;
  logic [DW-1:0]         wr_data_i, bank_wr_data_o, bank_rsp_data_i, rsp_data_o;
  logic                  bank_wr_valid_o, bank_wr_ready_i, bank_rd_valid_o, bank_rd_ready_i;
  logic                  bank_rsp_valid_i;
  logic [TW-1:0]         rsp_tag_o;

  register_file_bank_scheduler #(.NumReaders(N), .NumRegisters(NR), .DataWidth(DW),
                                 .TagWidth(TW), .MaxWrStreak(MS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i), .rd_tag_i(rd_tag_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .bank_wr_valid_o(bank_wr_valid_o), .bank_wr_addr_o(bank_wr_addr_o),
    .bank_wr_data_o(bank_wr_data_o), .bank_wr_ready_i(bank_wr_ready_i),
    .bank_rd_valid_o(bank_rd_valid_o), .bank_rd_addr_o(bank_rd_addr_o),
    .bank_rd_ready_i(bank_rd_ready_i),
    .bank_rsp_valid_i(bank_rsp_valid_i), .bank_rsp_data_i(bank_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o)
  );

  // Bank: always takes writes, takes a read only when no write is presented.
  logic [DW-1:0] bmem [NR];
  logic          brsp_v;
  logic [DW-1:0] brsp_d;
  assign bank_wr_ready_i  = rst_n;
  assign bank_rd_ready_i  = rst_n & ~bank_wr_valid_o;
  assign bank_rsp_valid_i = brsp_v;
  assign bank_rsp_data_i  = brsp_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brsp_v <= 1'b0;
      brsp_d <= '0;
    end else begin
      brsp_v <= bank_rd_valid_o & bank_rd_ready_i;
      if (bank_rd_valid_o & bank_rd_ready_i) brsp_d <= bmem[bank_rd_addr_o];
    end
  end
  always_ff @(posedge clk)
    if (rst_n && bank_wr_valid_o && bank_wr_ready_i) bmem[bank_wr_addr_o] <= bank_wr_data_o;

  // ---------------- single-reader DUT, guard disabled ----------------
  logic [0:0]          s_rd_valid, s_rd_ready, s_rsp_valid;
  logic [0:0][AW-1:0]  s_rd_addr;
  logic [0:0][TW-1:0]  s_rd_tag;
  logic                s_wr_valid, s_wr_ready, s_bwv, s_bwr, s_brv, s_brr, s_brsp_v;
  logic [AW-1:0]       s_wr_addr, s_bwa, s_bra;
  logic [DW-1:0]       s_wr_data, s_bwd, s_rsp_data;
  logic [TW-1:0]       s_rsp_tag;

  register_file_bank_scheduler #(.NumReaders(1), .NumRegisters(NR), .DataWidth(DW),
                                 .TagWidth(TW), .MaxWrStreak(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_valid_i(s_rd_valid), .rd_ready_o(s_rd_ready), .rd_addr_i(s_rd_addr), .rd_tag_i(s_rd_tag),
    .wr_valid_i(s_wr_valid), .wr_ready_o(s_wr_ready), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .bank_wr_valid_o(s_bwv), .bank_wr_addr_o(s_bwa), .bank_wr_data_o(s_bwd), .bank_wr_ready_i(s_bwr),
    .bank_rd_valid_o(s_brv), .bank_rd_addr_o(s_bra), .bank_rd_ready_i(s_brr),
    .bank_rsp_valid_i(s_brsp_v), .bank_rsp_data_i(32'h5A5A_0001),
    .rsp_valid_o(s_rsp_valid), .rsp_tag_o(s_rsp_tag), .rsp_data_o(s_rsp_data)
  );
  assign s_bwr = rst_n;
  assign s_brr = rst_n & ~s_bwv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_brsp_v <= 1'b0;
    else        s_brsp_v <= s_brv & s_brr;

  // ---------------- reference model ----------------
  int            npass = 0, ntot = 0;
  int            m_ptr, m_streak;
  bit            p_v;
  int            p_idx;
  logic [TW-1:0] p_tag;
  logic [DW-1:0] p_data;
  logic [DW-1:0] ref_mem [NR];
  bit            e_acc, e_bwv;
  int            e_g;
  bit            last_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_streak = 0; p_v = 0;
  endtask

  // Called at posedge+1 once inputs are set; checks the cycle's outputs.
  task automatic settle();
    bit any, frc;
    int g;
    #3;
    any = |rd_valid_i;
    frc = (MS != 0) && (m_streak == MS) && any;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && rd_valid_i[idx]) g = idx;
    end
    e_bwv = wr_valid_i && !frc;
    e_acc = any && !e_bwv;
    e_g   = g;
    chk("wr_ready", wr_ready_o, !frc);
    chk("bank_wr_valid", bank_wr_valid_o, e_bwv);
    if (e_bwv) begin
      chk("bank_wr_addr", bank_wr_addr_o, wr_addr_i);
      chk("bank_wr_data", bank_wr_data_o, wr_data_i);
    end
    chk("bank_rd_valid", bank_rd_valid_o, any);
    if (any) chk("bank_rd_addr", bank_rd_addr_o, rd_addr_i[g]);
    chk("rd_ready", rd_ready_o, e_acc ? (64'd1 << g) : 64'd0);
    chk("rsp_valid", rsp_valid_o, p_v ? (64'd1 << p_idx) : 64'd0);
    if (p_v) begin
      chk("rsp_tag", rsp_tag_o, p_tag);
      chk("rsp_data", rsp_data_o, p_data);
    end
  endtask

  // Advances the model by the cycle's outcome, then moves to next posedge+1.
  task automatic commit();
    if (e_bwv) ref_mem[wr_addr_i] = wr_data_i;
    if (e_acc) begin
      p_v = 1; p_idx = e_g; p_tag = rd_tag_i[e_g]; p_data = ref_mem[rd_addr_i[e_g]];
      m_ptr = (e_g + 1) % N; m_streak = 0;
    end else begin
      p_v = 0;
      if (rd_valid_i == '0) m_streak = 0;
      else if (m_streak < MS) m_streak++;
    end
    last_w = e_bwv;
    @(posedge clk); #1;
    if (e_acc) rd_valid_i[e_g] = 1'b0;
  endtask

  task automatic step();
    settle(); commit();
  endtask

  initial begin
    rd_valid_i = '0; rd_addr_i = '0; rd_tag_i = '0;
    wr_valid_i = 0; wr_addr_i = '0; wr_data_i = '0;
    s_rd_valid = '0; s_rd_addr = '0; s_rd_tag = '0;
    s_wr_valid = 0; s_wr_addr = '0; s_wr_data = '0;
    model_reset();

    // Reset state
    #2;
    chk("rst_rd_ready", rd_ready_o, 0);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_bank_rd_valid", bank_rd_valid_o, 0);
    chk("rst_bank_wr_valid", bank_wr_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_tag", rsp_tag_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Preload every register so reads always have defined data.
    for (int r = 0; r < NR; r++) begin
      wr_valid_i = 1; wr_addr_i = AW'(r); wr_data_i = $urandom;
      step();
    end
    wr_valid_i = 0;

    // Round robin: all readers valid, addrs 4..7
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) begin
        rd_addr_i[j] = AW'(4 + j); rd_tag_i[j] = TW'(8 + j);
      end
      rd_valid_i = '1;
      settle();
      chk("rr_grant", rd_ready_o, 64'd1 << (i % 4));
      if (i > 0) chk("rr_rsp", rsp_valid_o, 64'd1 << ((i - 1) % 4));
      commit();
    end
    rd_valid_i = '0;
    step();

    // Reset mid-read: reader 2 accepted, reset lands in its response cycle
    rd_valid_i = 4'b0100; rd_addr_i[2] = 5'd11; rd_tag_i[2] = 4'hC;
    step();
    rst_n = 0; #1;
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_rsp_tag", rsp_tag_o, 0);
    rd_valid_i = '0; wr_valid_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    settle();
    chk("post_rst_rsp", rsp_valid_o, 0);
    chk("post_rst_bank_rd", bank_rd_valid_o, 0);
    commit();
    rd_valid_i = '1;
    settle();
    chk("post_rst_first_grant", rd_ready_o, 4'b0001);
    commit();
    rd_valid_i = '0;
    step();

    // Write priority: write and rd[2] together, read goes next idle cycle
    wr_valid_i = 1; wr_addr_i = 5'd20; wr_data_i = 32'h1234_5678;
    rd_valid_i = 4'b0100; rd_addr_i[2] = 5'd3; rd_tag_i[2] = 4'h2;
    settle();
    chk("wp_wr_ready", wr_ready_o, 1);
    chk("wp_rd_ready", rd_ready_o, 0);
    commit();
    wr_valid_i = 0;
    settle();
    chk("wp_rd_after", rd_ready_o, 4'b0100);
    commit();
    step();

    // Starvation guard: 10 back-to-back writes vs reader 1
    rd_valid_i = 4'b0010; rd_addr_i[1] = 5'd20; rd_tag_i[1] = 4'h5;
    for (int c = 0; c < 10; c++) begin
      wr_valid_i = 1; wr_addr_i = AW'(12 + c); wr_data_i = $urandom;
      settle();
      chk("sv_wr_ready", wr_ready_o, (c != 3));
      chk("sv_rd_ready", rd_ready_o, (c == 3) ? 4'b0010 : 4'b0000);
      chk("sv_rsp", rsp_valid_o, (c == 4) ? 4'b0010 : 4'b0000);
      commit();
    end
    wr_valid_i = 0;

    // Write then read-back coherence
    wr_valid_i = 1; wr_addr_i = 5'd9; wr_data_i = 32'hDEADBEEF;
    step();
    wr_valid_i = 0;
    rd_valid_i = 4'b1000; rd_addr_i[3] = 5'd9; rd_tag_i[3] = 4'hA;
    settle();
    chk("coh_grant", rd_ready_o, 4'b1000);
    commit();
    settle();
    chk("coh_rsp_valid", rsp_valid_o, 4'b1000);
    chk("coh_rsp_data", rsp_data_o, 32'hDEADBEEF);
    chk("coh_rsp_tag", rsp_tag_o, 4'hA);
    commit();

    // Wrap: drive ptr to 3, then only reader 0 -> ptr becomes 1
    rd_valid_i = 4'b0100; step();
    rd_valid_i = 4'b0001;
    settle(); chk("wrap_grant0", rd_ready_o, 4'b0001); commit();
    rd_valid_i = 4'b0011;
    settle(); chk("wrap_ptr1", rd_ready_o, 4'b0010); commit();
    rd_valid_i = '0;
    step(); step();

    // Single reader, guard disabled: continuous writes starve the reader
    for (int c = 0; c < 12; c++) begin
      s_rd_valid = (c <= 10); s_rd_addr[0] = 5'd2; s_rd_tag[0] = 4'h6;
      s_wr_valid = (c < 10); s_wr_addr = AW'(c); s_wr_data = 32'(c);
      settle();
      chk("single_wr_ready", s_wr_ready, 1);
      chk("single_rd_ready", s_rd_ready, (c == 10));
      chk("single_rsp", s_rsp_valid, (c == 11));
      if (c == 11) chk("single_rsp_tag", s_rsp_tag, 4'h6);
      commit();
    end
    s_rd_valid = '0; s_wr_valid = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        if (!rd_valid_i[j] && ($urandom_range(0, 99) < 35)) begin
          rd_valid_i[j] = 1; rd_addr_i[j] = AW'($urandom); rd_tag_i[j] = TW'($urandom);
        end
      if (!wr_valid_i || last_w) begin
        wr_valid_i = ($urandom_range(0, 99) < 55);
        wr_addr_i = AW'($urandom); wr_data_i = $urandom;
      end
      settle(); commit();
    end
    rd_valid_i = '0; wr_valid_i = 0;
    step(); step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
